shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameters: none; widths come from the package (DATA_W=32, AMT_W=5).
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 req0_valid  in  1  requester 0 has a shift operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle when valid and ready are both high.
REQ-006 req0_data  in  32  requester 0 operand.
REQ-007 req0_amt  in  5  requester 0 right-shift amount, 0..31.
REQ-008 req0_arith  in  1  requester 0 sign-fill request; present only with SHIFT_ARB_SRA_EN.
REQ-009 req1_valid, req1_ready, req1_data, req1_amt, req1_arith: same as REQ-004..008, for requester 1.
REQ-010 out_valid  out  1  result register holds a valid result.
REQ-011 out_ready  in  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-012 out_data  out  32  shifted result.
REQ-013 out_src  out  1  index of the requester that owns out_data.

Function
REQ-014 One combinational right shifter is shared; both requesters reach it only through the arbiter.
REQ-015 can_accept = !out_valid || out_ready.
- Accepting while the output register drains in the same cycle is legal.
REQ-016 Grant selection, evaluated every cycle:
- Only one requester valid: that requester gets the grant.
- Both valid: the requester not granted last gets the grant (round-robin).
- Neither valid: no grant.
REQ-017 reqN_ready = grantN && can_accept.
- Purely combinational; never depends on reqN_ready of the other port.
- At most one ready is high per cycle.
REQ-018 On acceptance at edge N:
- out_data = reqN_data >> reqN_amt.
- out_src = N.
- out_valid = 1, visible after edge N (latency 1 cycle).
REQ-019 Without acceptance:
- out_valid clears on a handshake (out_valid && out_ready).
- out_valid holds otherwise; out_data and out_src stay stable while out_valid && !out_ready.
REQ-020 Throughput is one operation per cycle while out_ready stays high.
REQ-021 The last-grant pointer updates only on acceptance, not on grant alone.
REQ-022 amt=0 passes data unchanged; amt=31 leaves bit 31 of the input in bit 0.
- Vacated bits are filled with 0 unless arithmetic mode is active (REQ-026).
REQ-023 A requester keeps data, amt and arith stable and valid high until accepted; the arbiter does not check this.
REQ-024 FSM states:
- EMPTY (out_valid=0) -> FULL on acceptance.
- FULL: stays FULL on drain-and-accept in the same cycle, or on stall.
- FULL -> EMPTY on a drain with no acceptance.

Reset
REQ-025 While resetn is low, these are asserted immediately (not on an edge):
- out_valid=0, out_data=0, out_src=0.
- FSM=EMPTY; the last-grant pointer is set so requester 0 wins the first tie.
- An in-flight result is discarded; no handshake completes during reset.

Configuration
REQ-026 SHIFT_ARB_SRA_EN defined:
- reqN_arith ports exist.
- With arith=1, vacated bits are filled with bit 31 of the operand.
REQ-027 SHIFT_ARB_SRA_EN undefined:
- The arith ports are absent.
- Fill is always 0 (logical shift only).

Structure
REQ-028 Package shift_arb_pkg contains:
- DATA_W and AMT_W constants.
- The FSM state typedef (EMPTY, FULL).
- The request struct (data, amt, arith).
REQ-029 Sub-module shift_core_r:
- Combinational 5-stage right barrel shifter with a fill-bit input.
- Instantiated once inside shift_arbiter.

Verification
REQ-030 req0 only: data=0x80000000, amt=4, out_ready=1 -> next cycle out_valid=1, out_data=0x08000000, out_src=0.
REQ-031 Both valid every cycle, out_ready=1 from reset -> out_src sequence is 0,1,0,1; one result per cycle.
REQ-032 out_ready=0 with a result held, req1 valid:
- req1_ready stays low; out_data is stable.
- After out_ready goes to 1, that cycle drains the result and accepts req1 together.
REQ-033 SRA_EN build, data=0xF0000000, amt=31:
- arith=1 -> 0xFFFFFFFF.
- arith=0 -> 0x00000001.
REQ-034 Assert resetn low mid-stream while out_valid=1 -> out_valid drops immediately; after release, a tie is granted to req0 first.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared widths, FSM state type and request payload for the shift arbiter.
package shift_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        logic              arith;
    } shift_req_t;

endpackage

// File: rtl/shift_core_r.sv
// Combinational right barrel shifter, one stage per amount bit.
// Ports:
//   i_data   operand
//   i_amt    right-shift amount
//   i_fill   value shifted into the vacated high bits
//   o_data_c shifted result (combinational)
module shift_core_r
    import shift_arb_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMT_W-1:0]  i_amt,
    input  logic              i_fill,
    output logic [DATA_W-1:0] o_data_c
);

    logic [DATA_W-1:0] w_stage [AMT_W+1];

    assign w_stage[0] = i_data;

    // Stage k shifts by 2**k when amount bit k is set.
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int unsigned SH = 1 << k;
        assign w_stage[k+1] = i_amt[k] ? {{SH{i_fill}}, w_stage[k][DATA_W-1:SH]}
                                       : w_stage[k];
    end

    assign o_data_c = w_stage[AMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared right shifter,
// with a single registered result slot.
// Build option: define SHIFT_ARB_SRA_EN to add reqN_arith ports
// (sign-fill shifts); otherwise only logical shifts are performed.
// Ports:
//   clock, resetn               clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake for requester N
//   reqN_data/amt(/arith)       request operand, shift amount (sign-fill)
//   out_valid/ready             result handshake
//   out_data, out_src           shifted result and owning requester
module shift_arbiter
    import shift_arb_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
`ifdef SHIFT_ARB_SRA_EN
    input  logic              req0_arith,
`endif
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
`ifdef SHIFT_ARB_SRA_EN
    input  logic              req1_arith,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last;
    logic [DATA_W-1:0] r_data;
    logic              r_src;

    shift_req_t        w_req0;
    shift_req_t        w_req1;
    shift_req_t        w_sel;
    logic              w_sel_idx;
    logic              w_any_valid;
    logic              w_can_accept;
    logic              w_accept;
    logic              w_fill;
    logic [DATA_W-1:0] w_shifted;

    // Pack request ports; arith is tied low when sign-fill is not built.
    always_comb begin
        w_req0.data  = req0_data;
        w_req0.amt   = req0_amt;
        w_req1.data  = req1_data;
        w_req1.amt   = req1_amt;
`ifdef SHIFT_ARB_SRA_EN
        w_req0.arith = req0_arith;
        w_req1.arith = req1_arith;
`else
        w_req0.arith = 1'b0;
        w_req1.arith = 1'b0;
`endif
    end

    // Round-robin grant: on a tie the requester not granted last wins.
    always_comb begin
        w_any_valid  = req0_valid | req1_valid;
        w_sel_idx    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
        w_sel        = w_sel_idx ? w_req1 : w_req0;
        w_can_accept = (r_state == ST_EMPTY) || out_ready;
        w_accept     = w_any_valid && w_can_accept;
        w_fill       = w_sel.arith & w_sel.data[DATA_W-1];
    end

    // Ready is gated by reset so no handshake can appear to complete in reset.
    assign req0_ready = resetn && w_accept && !w_sel_idx;
    assign req1_ready = resetn && w_accept &&  w_sel_idx;

    shift_core_r u_core (
        .i_data   (w_sel.data),
        .i_amt    (w_sel.amt),
        .i_fill   (w_fill),
        .o_data_c (w_shifted)
    );

    // Result slot state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot stays FULL on accept (including drain-and-accept) or stall.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (!w_accept && out_ready) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Result payload and last-grant pointer move only on acceptance;
    // pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_data <= '0;
            r_src  <= 1'b0;
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_data <= w_shifted;
            r_src  <= w_sel_idx;
            r_last <= w_sel_idx;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, ar0 = 1'b0, ar1 = 1'b0, ordy = 1'b0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [4:0]  a0 = '0, a1 = '0;
    logic        r0, r1, ov, osrc;
    logic [31:0] od;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    shift_arbiter dut (
        .clock      (clock),
        .resetn     (resetn),
        .req0_valid (v0),
        .req0_ready (r0),
        .req0_data  (d0),
        .req0_amt   (a0),
`ifdef SHIFT_ARB_SRA_EN
        .req0_arith (ar0),
`endif
        .req1_valid (v1),
        .req1_ready (r1),
        .req1_data  (d1),
        .req1_amt   (a1),
`ifdef SHIFT_ARB_SRA_EN
        .req1_arith (ar1),
`endif
        .out_valid  (ov),
        .out_ready  (ordy),
        .out_data   (od),
        .out_src    (osrc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv0, input logic [31:0] id0, input logic [4:0] ia0,
                         input logic iar0, input logic iv1, input logic [31:0] id1,
                         input logic [4:0] ia1, input logic iar1, input logic iordy);
        v0 = iv0; d0 = id0; a0 = ia0; ar0 = iar0;
        v1 = iv1; d1 = id1; a1 = ia1; ar1 = iar1;
        ordy = iordy;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #2 resetn = 1'b1;
    endtask

    // Reference: plain shift, or sign extension of the operand when arith.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                              input logic ar);
        if (ar && d[31]) return ~((~d) >> a);
        return d >> a;
    endfunction

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic [4:0]  a0;
        logic        v1;
        logic [31:0] d1;
        logic [4:0]  a1;
        logic        ordy;
        logic        e_r0;
        logic        e_r1;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_src;
    } vec_t;

    vec_t tbl [8];

    // Random-phase model state and pending requests.
    logic        m_valid, m_src, m_last;
    logic [31:0] m_data;
    logic        p0, p1, pa0, pa1;
    logic [31:0] pd0, pd1;
    logic [4:0]  pa_0, pa_1;

    initial begin
        // Expected outputs reflect the state before the edge that follows each row.
        tbl[0] = '{1, 32'h8000_0000, 5'd4,  0, 32'h0,         5'd0, 1, 1, 0, 0, 32'h0000_0000, 0};
        tbl[1] = '{0, 32'h0,         5'd0,  1, 32'h1234_5678, 5'd0, 1, 0, 1, 1, 32'h0800_0000, 0};
        tbl[2] = '{1, 32'hFFFF_FFFF, 5'd31, 0, 32'h0,         5'd0, 0, 0, 0, 1, 32'h1234_5678, 1};
        tbl[3] = '{1, 32'hFFFF_FFFF, 5'd31, 0, 32'h0,         5'd0, 1, 1, 0, 1, 32'h1234_5678, 1};
        tbl[4] = '{0, 32'h0,         5'd0,  0, 32'h0,         5'd0, 1, 0, 0, 1, 32'h0000_0001, 0};
        tbl[5] = '{0, 32'h0,         5'd0,  0, 32'h0,         5'd0, 0, 0, 0, 0, 32'h0000_0001, 0};
        tbl[6] = '{0, 32'h0,         5'd0,  1, 32'h0000_00FF, 5'd0, 0, 0, 1, 0, 32'h0000_0001, 0};
        tbl[7] = '{1, 32'h5,         5'd1,  1, 32'h0000_00FF, 5'd0, 0, 0, 0, 1, 32'h0000_00FF, 1};

        do_reset();
        #1;
        check("reset_out_valid", 32'(ov), 32'h0);
        check("reset_out_data", od, 32'h0);
        check("reset_out_src", 32'(osrc), 32'h0);

        // Table-driven directed vectors.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            drive(tbl[i].v0, tbl[i].d0, tbl[i].a0, 0, tbl[i].v1, tbl[i].d1, tbl[i].a1, 0, tbl[i].ordy);
            #1;
            check($sformatf("tbl%0d_req0_ready", i), 32'(r0), 32'(tbl[i].e_r0));
            check($sformatf("tbl%0d_req1_ready", i), 32'(r1), 32'(tbl[i].e_r1));
            check($sformatf("tbl%0d_out_valid", i), 32'(ov), 32'(tbl[i].e_ov));
            check($sformatf("tbl%0d_out_data", i), od, tbl[i].e_od);
            check($sformatf("tbl%0d_out_src", i), 32'(osrc), 32'(tbl[i].e_src));
        end

        // Tie every cycle from reset: alternating grants, one result per cycle.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            drive(1, 32'h1111_0000, 5'd16, 0, 1, 32'h2222_0000, 5'd16, 0, 1);
            #1;
            check($sformatf("rr%0d_req0_ready", c), 32'(r0), 32'((c % 2) == 0));
            check($sformatf("rr%0d_req1_ready", c), 32'(r1), 32'((c % 2) == 1));
            check($sformatf("rr%0d_out_valid", c), 32'(ov), 32'(c != 0));
            if (c != 0) begin
                check($sformatf("rr%0d_out_src", c), 32'(osrc), 32'((c - 1) % 2));
                check($sformatf("rr%0d_out_data", c), od, ((c - 1) % 2 == 0) ? 32'h1111 : 32'h2222);
            end
        end

        // Stall with a held result, then drain-and-accept in one cycle.
        do_reset();
        @(negedge clock);
        drive(1, 32'hDEAD_BEEF, 5'd8, 0, 0, 0, 0, 0, 0);
        #1 check("stall_first_accept", 32'(r0), 32'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive(0, 0, 0, 0, 1, 32'h0000_F000, 5'd12, 0, 0);
            #1;
            check($sformatf("stall%0d_req1_ready", c), 32'(r1), 32'h0);
            check($sformatf("stall%0d_out_valid", c), 32'(ov), 32'h1);
            check($sformatf("stall%0d_out_data", c), od, 32'h00DE_ADBE);
        end
        @(negedge clock);
        ordy = 1'b1;
        #1;
        check("drain_req1_ready", 32'(r1), 32'h1);
        check("drain_old_data", od, 32'h00DE_ADBE);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        check("drain_new_valid", 32'(ov), 32'h1);
        check("drain_new_data", od, 32'h0000_000F);
        check("drain_new_src", 32'(osrc), 32'h1);
        @(negedge clock);
        #1 check("drain_empty", 32'(ov), 32'h0);

`ifdef SHIFT_ARB_SRA_EN
        // Sign-fill versus zero-fill at the maximum shift amount.
        do_reset();
        @(negedge clock);
        drive(1, 32'hF000_0000, 5'd31, 1, 0, 0, 0, 0, 1);
        @(negedge clock);
        drive(1, 32'hF000_0000, 5'd31, 0, 0, 0, 0, 0, 1);
        #1 check("sra_arith1", od, 32'hFFFF_FFFF);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 check("sra_arith0", od, 32'h0000_0001);
`endif

        // Asynchronous reset while a result is held.
        do_reset();
        @(negedge clock);
        drive(0, 0, 0, 0, 1, 32'h0000_0100, 5'd0, 0, 0);
        @(negedge clock);
        drive(1, 32'h7, 5'd0, 0, 1, 32'h0000_0100, 5'd0, 0, 0);
        #1 check("pre_reset_valid", 32'(ov), 32'h1);
        #1 resetn = 1'b0;
        #1;
        check("async_reset_valid", 32'(ov), 32'h0);
        check("async_reset_data", od, 32'h0);
        check("async_reset_src", 32'(osrc), 32'h0);
        check("async_reset_ready0", 32'(r0), 32'h0);
        @(posedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        ordy = 1'b1;
        #1;
        check("post_reset_tie_req0", 32'(r0), 32'h1);
        check("post_reset_tie_req1", 32'(r1), 32'h0);
        @(negedge clock);
        #1 check("post_reset_src", 32'(osrc), 32'h0);

        // Randomized traffic against a rule-level model.
        do_reset();
        m_valid = 0; m_src = 0; m_last = 1; m_data = '0;
        p0 = 0; p1 = 0; pa0 = 0; pa1 = 0; pd0 = '0; pd1 = '0; pa_0 = '0; pa_1 = '0;
        for (int c = 0; c < 400; c++) begin
            logic g, acc, can;
            @(negedge clock);
            if (!p0 && ($urandom % 3 != 0)) begin
                p0 = 1; pd0 = $urandom;
                pa_0 = ($urandom % 4 == 0) ? (($urandom % 2 == 0) ? 5'd0 : 5'd31) : 5'($urandom % 32);
`ifdef SHIFT_ARB_SRA_EN
                pa0 = 1'($urandom % 2);
`endif
            end
            if (!p1 && ($urandom % 3 != 0)) begin
                p1 = 1; pd1 = $urandom;
                pa_1 = ($urandom % 4 == 0) ? (($urandom % 2 == 0) ? 5'd0 : 5'd31) : 5'($urandom % 32);
`ifdef SHIFT_ARB_SRA_EN
                pa1 = 1'($urandom % 2);
`endif
            end
            drive(p0, pd0, pa_0, pa0, p1, pd1, pa_1, pa1, ($urandom % 4 != 0));
            #1;
            g   = (p0 && p1) ? !m_last : p1;
            can = !m_valid || ordy;
            acc = (p0 || p1) && can;
            check("rnd_req0_ready", 32'(r0), 32'(acc && !g));
            check("rnd_req1_ready", 32'(r1), 32'(acc && g));
            check("rnd_out_valid", 32'(ov), 32'(m_valid));
            if (m_valid) begin
                check("rnd_out_data", od, m_data);
                check("rnd_out_src", 32'(osrc), 32'(m_src));
            end
            @(posedge clock);
            if (acc) begin
                m_data  = g ? ref_shift(pd1, pa_1, pa1) : ref_shift(pd0, pa_0, pa0);
                m_src   = g;
                m_last  = g;
                m_valid = 1;
                if (g) p1 = 0; else p0 = 0;
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
